score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 172 +++++++++++++++++
 tb/tb_score_keeper.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Rhythm-game score keeper: grades timing error, tracks combo and multiplier,
// and accumulates a saturating score through a two-stage pipeline.
module score_keeper #(
    parameter logic [15:0] PERFECT_WIN = 16'd25,
    parameter logic [15:0] GREAT_WIN   = 16'd60,
    parameter logic [15:0] GOOD_WIN    = 16'd120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        match_en,
    input  logic [15:0] match_dt,
    input  logic        miss_en,
    output logic [23:0] score,
    output logic [9:0]  combo,
    output logic [9:0]  max_combo,
    output logic [2:0]  multiplier,
    output logic [1:0]  grade,
    output logic        grade_valid
);

    localparam logic [1:0] G_MISS    = 2'd0;
    localparam logic [1:0] G_GOOD    = 2'd1;
    localparam logic [1:0] G_GREAT   = 2'd2;
    localparam logic [1:0] G_PERFECT = 2'd3;

    localparam logic [9:0]  COMBO_MAX = 10'd1023;
    localparam logic [23:0] SCORE_MAX = 24'hFFFFFF;

    logic [15:0] abs_d;
    logic        s1_hit_q;
    logic        s1_miss_q;
    logic [15:0] s1_abs_q;

    logic [23:0] score_q, score_d;
    logic [9:0]  combo_q, combo_d;
    logic [9:0]  max_q, max_d;
    logic [2:0]  mult_q, mult_d;
    logic [1:0]  grade_q, grade_d;
    logic        gv_q, gv_d;

    logic [1:0]  s1_grade;
    logic        eff_hit;
    logic        eff_miss;
    logic [6:0]  base_c;
    logic [2:0]  mult_used;
    logic [9:0]  add_c;
    logic [24:0] sum_c;
    logic [23:0] score_sat;
    logic [9:0]  combo_base;
    logic [9:0]  combo_inc;

    // -32768 has no positive twin in 16 bits, so it pins to the largest value
    always_comb begin
        abs_d = match_dt;
        if (match_dt[15]) begin
            if (match_dt == 16'h8000) begin
                abs_d = 16'h7FFF;
            end else begin
                abs_d = ~match_dt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_hit_q  <= 1'b0;
            s1_miss_q <= 1'b0;
            s1_abs_q  <= 16'd0;
        end else if (clear) begin
            s1_hit_q  <= 1'b0;
            s1_miss_q <= 1'b0;
        end else begin
            s1_hit_q  <= match_en;
            s1_miss_q <= miss_en;
            s1_abs_q  <= abs_d;
        end
    end

    always_comb begin
        if (s1_abs_q <= PERFECT_WIN) begin
            s1_grade = G_PERFECT;
        end else if (s1_abs_q <= GREAT_WIN) begin
            s1_grade = G_GREAT;
        end else if (s1_abs_q <= GOOD_WIN) begin
            s1_grade = G_GOOD;
        end else begin
            s1_grade = G_MISS;
        end
    end

    assign eff_hit  = s1_hit_q && (s1_grade != G_MISS);
    assign eff_miss = s1_miss_q || (s1_hit_q && (s1_grade == G_MISS));

    always_comb begin
        unique case (s1_grade)
            G_PERFECT: base_c = 7'd100;
            G_GREAT:   base_c = 7'd50;
            G_GOOD:    base_c = 7'd25;
            G_MISS:    base_c = 7'd0;
            default:   base_c = 7'd0;
        endcase
    end

    // A miss in the same cycle resets the multiplier before the hit scores
    assign mult_used = eff_miss ? 3'd1 : mult_q;
    assign add_c     = {3'd0, base_c} * {7'd0, mult_used};
    assign sum_c     = {1'b0, score_q} + {15'd0, add_c};
    assign score_sat = sum_c[24] ? SCORE_MAX : sum_c[23:0];

    assign combo_base = eff_miss ? 10'd0 : combo_q;
    assign combo_inc  = (combo_base == COMBO_MAX) ? COMBO_MAX
                                                  : combo_base + 10'd1;

    always_comb begin
        combo_d = eff_hit ? combo_inc : combo_base;
        score_d = eff_hit ? score_sat : score_q;
        max_d   = (combo_d > max_q) ? combo_d : max_q;
        gv_d    = eff_hit || eff_miss;
        grade_d = grade_q;
        if (eff_hit) begin
            grade_d = s1_grade;
        end else if (eff_miss) begin
            grade_d = G_MISS;
        end
    end

    always_comb begin
        if (combo_d >= 10'd30) begin
            mult_d = 3'd4;
        end else if (combo_d >= 10'd20) begin
            mult_d = 3'd3;
        end else if (combo_d >= 10'd10) begin
            mult_d = 3'd2;
        end else begin
            mult_d = 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q <= 24'd0;
            combo_q <= 10'd0;
            max_q   <= 10'd0;
            mult_q  <= 3'd1;
            grade_q <= G_MISS;
            gv_q    <= 1'b0;
        end else if (clear) begin
            score_q <= 24'd0;
            combo_q <= 10'd0;
            max_q   <= 10'd0;
            mult_q  <= 3'd1;
            grade_q <= G_MISS;
            gv_q    <= 1'b0;
        end else begin
            score_q <= score_d;
            combo_q <= combo_d;
            max_q   <= max_d;
            mult_q  <= mult_d;
            grade_q <= grade_d;
            gv_q    <= gv_d;
        end
    end

    assign score       = score_q;
    assign combo       = combo_q;
    assign max_combo   = max_q;
    assign multiplier  = mult_q;
    assign grade       = grade_q;
    assign grade_valid = gv_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_score_keeper;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        match_en;
    logic [15:0] match_dt;
    logic        miss_en;
    logic [23:0] score;
    logic [9:0]  combo;
    logic [9:0]  max_combo;
    logic [2:0]  multiplier;
    logic [1:0]  grade;
    logic        grade_valid;

    int n_tests = 0;
    int n_fail  = 0;

    int m_score, m_combo, m_max, m_grade;
    bit m_gv;

    logic [49:0] act;

    score_keeper dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .match_en(match_en),
        .match_dt(match_dt),
        .miss_en(miss_en),
        .score(score),
        .combo(combo),
        .max_combo(max_combo),
        .multiplier(multiplier),
        .grade(grade),
        .grade_valid(grade_valid)
    );

    assign act = {score, combo, max_combo, multiplier, grade, grade_valid};

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int mult_of(input int c);
        int m;
        m = 1 + c / 10;
        return (m > 4) ? 4 : m;
    endfunction

    function automatic logic [49:0] cv(input int s, input int c, input int mx,
                                       input int mu, input int g, input int v);
        return {24'(s), 10'(c), 10'(mx), 3'(mu), 2'(g), 1'(v)};
    endfunction

    function automatic logic [49:0] exp_vec();
        return cv(m_score, m_combo, m_max, mult_of(m_combo), m_grade, int'(m_gv));
    endfunction

    function automatic void model_clear();
        m_score = 0; m_combo = 0; m_max = 0; m_grade = 0; m_gv = 0;
    endfunction

    function automatic void model(input bit h, input logic [15:0] dt, input bit ms);
        int d, a, g, base;
        bit hit, miss;
        d = int'($signed(dt));
        a = (d < 0) ? -d : d;
        if (a > 32767) a = 32767;
        g = (a <= 25) ? 3 : (a <= 60) ? 2 : (a <= 120) ? 1 : 0;
        hit  = h && (g != 0);
        miss = ms || (h && (g == 0));
        m_gv = hit || miss;
        if (miss) begin
            m_combo = 0;
            m_grade = 0;
        end
        if (hit) begin
            base = (g == 3) ? 100 : (g == 2) ? 50 : 25;
            m_score = m_score + base * mult_of(m_combo);
            if (m_score > 24'hFFFFFF) m_score = 24'hFFFFFF;
            m_combo = (m_combo >= 1023) ? 1023 : m_combo + 1;
            m_grade = g;
        end
        if (m_combo > m_max) m_max = m_combo;
    endfunction

    task automatic tick(input bit h, input logic [15:0] dt, input bit ms);
        @(negedge clk);
        match_en = h;
        match_dt = dt;
        miss_en  = ms;
    endtask

    task automatic ev(input bit h, input logic [15:0] dt, input bit ms);
        tick(h, dt, ms);
        model(h, dt, ms);
    endtask

    task automatic flush();
        repeat (3) ev(1'b0, 16'd0, 1'b0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        match_en = 0; miss_en = 0; clear = 1;
        @(negedge clk);
        clear = 0;
        model_clear();
    endtask

    task automatic test_reset();
        logic [49:0] e;
        #1;
        e = cv(0, 0, 0, 1, 0, 0);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL reset_state got=%h want=%h", act, e);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        model_clear();
        flush();
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL reset_release got=%h want=%h", act, e);
        end
    endtask

    task automatic test_pair();
        logic [49:0] e;
        do_clear();
        ev(1, 16'd10, 0);
        ev(1, 16'(-25), 0);
        ev(0, 16'd0, 0);
        e = cv(100, 1, 1, 1, 3, 1);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL pair_first got=%h want=%h", act, e);
        end
        ev(0, 16'd0, 0);
        e = cv(200, 2, 2, 1, 3, 1);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL pair_second got=%h want=%h", act, e);
        end
        ev(0, 16'd0, 0);
        e = cv(200, 2, 2, 1, 3, 0);
        n_tests++;
        if (act !== e || exp_vec() !== e) begin
            n_fail++;
            $display("FAIL pair_idle got=%h want=%h", act, e);
        end
    endtask

    task automatic test_combo_mult();
        logic [49:0] e;
        do_clear();
        repeat (9) ev(1, 16'd0, 0);
        ev(1, 16'(-60), 0);
        flush();
        e = cv(950, 10, 10, 2, 2, 0);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL combo10_great got=%h want=%h", act, e);
        end
        ev(1, 16'd0, 0);
        flush();
        e = cv(1150, 11, 11, 2, 3, 0);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL combo_x2_perfect got=%h want=%h", act, e);
        end
    endtask

    task automatic test_miss_paths();
        logic [49:0] e;
        ev(1, 16'd121, 0);
        flush();
        e = cv(1150, 0, 11, 1, 0, 0);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL miss_dt121 got=%h want=%h", act, e);
        end
        repeat (3) ev(1, 16'd0, 0);
        ev(1, 16'h8000, 0);
        flush();
        e = cv(1450, 0, 11, 1, 0, 0);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL miss_dt8000 got=%h want=%h", act, e);
        end
        repeat (2) ev(1, 16'd0, 0);
        ev(0, 16'd0, 1);
        flush();
        e = cv(1650, 0, 11, 1, 0, 0);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL miss_en got=%h want=%h", act, e);
        end
    endtask

    task automatic test_boundaries();
        logic [49:0] e;
        do_clear();
        ev(1, 16'd25, 0);
        ev(1, 16'd26, 0);
        ev(1, 16'(-61), 0);
        flush();
        e = cv(175, 3, 3, 1, 1, 0);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL bound_25_26_61 got=%h want=%h", act, e);
        end
        ev(1, 16'(-120), 0);
        flush();
        e = cv(200, 4, 4, 1, 1, 0);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL bound_120 got=%h want=%h", act, e);
        end
        ev(1, 16'(-121), 0);
        flush();
        e = cv(200, 0, 4, 1, 0, 0);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL bound_121 got=%h want=%h", act, e);
        end
    endtask

    task automatic test_simultaneous();
        logic [49:0] e;
        do_clear();
        repeat (15) ev(1, 16'd0, 0);
        flush();
        e = cv(2000, 15, 15, 2, 3, 0);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL simul_pre got=%h want=%h", act, e);
        end
        ev(1, 16'd0, 1);
        ev(0, 16'd0, 0);
        ev(0, 16'd0, 0);
        e = cv(2100, 1, 15, 1, 3, 1);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL simul_event got=%h want=%h", act, e);
        end
        ev(0, 16'd0, 0);
        e = cv(2100, 1, 15, 1, 3, 0);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL simul_single_pulse got=%h want=%h", act, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [49:0] q[$];
        logic [49:0] e;
        logic [15:0] dt;
        bit h, ms;
        int errs;
        errs = 0;
        do_clear();
        for (int i = 0; i < 602; i++) begin
            h  = (i < 600) && ($urandom_range(0, 9) < 6);
            ms = (i < 600) && ($urandom_range(0, 9) < 2);
            dt = 16'($urandom_range(0, 140));
            if ($urandom_range(0, 1) == 1) dt = -dt;
            if ($urandom_range(0, 29) == 0) dt = 16'h8000;
            tick(h, dt, ms);
            if (q.size() >= 2) begin
                e = q.pop_front();
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    errs++;
                    if (errs < 10)
                        $display("FAIL random_cycle%0d got=%h want=%h", i, act, e);
                end
            end
            model(h, dt, ms);
            q.push_back(exp_vec());
        end
    endtask

    task automatic test_async_reset();
        logic [49:0] e;
        do_clear();
        repeat (3) ev(1, 16'd0, 0);
        ev(1, 16'd0, 0);
        tick(0, 16'd0, 0);
        @(posedge clk);
        #2;
        reset = 1;
        #1;
        e = cv(0, 0, 0, 1, 0, 0);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL async_reset_now got=%h want=%h", act, e);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            ev(0, 16'd0, 0);
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL async_reset_after%0d got=%h want=%h", i, act, e);
            end
        end
    endtask

    task automatic test_clear();
        logic [49:0] e;
        do_clear();
        repeat (4) ev(1, 16'd0, 0);
        ev(1, 16'd0, 0);
        @(negedge clk);
        clear = 1; match_en = 1; match_dt = 16'd0; miss_en = 1;
        model_clear();
        e = cv(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            ev(0, 16'd0, 0);
            clear = 0;
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL clear_after%0d got=%h want=%h", i, act, e);
            end
        end
    endtask

    task automatic test_saturation();
        logic [49:0] e;
        do_clear();
        repeat (700) ev(1, 16'd0, 0);
        flush();
        e = exp_vec();
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL sat_700 got=%h want=%h", act, e);
        end
        repeat (41500) ev(1, 16'd5, 0);
        flush();
        e = cv(24'hFFFFFF, 1023, 1023, 4, 3, 0);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL sat_pinned got=%h want=%h", act, e);
        end
        ev(1, 16'(-20), 0);
        flush();
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL sat_hold got=%h want=%h", act, e);
        end
    endtask

    initial begin
        clk = 0;
        reset = 1;
        clear = 0;
        match_en = 0;
        match_dt = 16'd0;
        miss_en = 0;
        model_clear();
        test_reset();
        test_pair();
        test_combo_mult();
        test_miss_paths();
        test_boundaries();
        test_simultaneous();
        test_back_to_back();
        test_async_reset();
        test_clear();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
